// File: rtl/arb_requester_if.sv
// Handshake bundle between the job source/arbiter side and arb_requester.
//   job_valid [2:0]       : per-master job offered (bit0=M1, bit1=M2, bit2=M3)
//   job_len   [3*LEN_W-1:0] : per-master job length, M1 in the low LEN_W bits
//   job_ready [2:0]       : per-master ready to accept a job
//   accmodule [1:0]       : grant code 00 none, 01 M1, 10 M2, 11 M3
//   req       [2:0]       : per-master memory request to the arbiter
//   done      [2:0]       : per-master end-of-access pulse to the arbiter
// master modport: job source + arbiter side; slave modport: the requester block.
interface arb_requester_if #(
    parameter int LEN_W = 4
);
    logic [2:0]         job_valid;
    logic [3*LEN_W-1:0] job_len;
    logic [2:0]         job_ready;
    logic [1:0]         accmodule;
    logic [2:0]         req;
    logic [2:0]         done;

    modport master (
        output job_valid, job_len, accmodule,
        input  job_ready, req, done
    );

    modport slave (
        input  job_valid, job_len, accmodule,
        output job_ready, req, done
    );
endinterface

// File: rtl/arb_requester.sv
// Three independent job requesters sharing one arbiter grant code.
// Each master accepts a job of job_len granted cycles, requests the arbiter,
// signals done on its last granted cycle and keeps statistics.
//   clk         : clock, rising edge
//   reset       : synchronous, active-high
//   bus         : arb_requester_if.slave handshake bundle
//   jobs_done   : per-master completed-job counters (wrap)
//   preempt_cnt : per-master grants lost before completion (saturating)
//   starved     : per-master sticky starvation flags
module arb_requester #(
    parameter int LEN_W        = 4,
    parameter int CNT_W        = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic               clk,
    input  logic               reset,
    arb_requester_if.slave     bus,
    output logic [3*CNT_W-1:0] jobs_done,
    output logic [3*CNT_W-1:0] preempt_cnt,
    output logic [2:0]         starved
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [1:0]       state_q [3];
    logic [1:0]       state_d [3];
    logic [LEN_W-1:0] rem_q   [3];
    logic [LEN_W-1:0] rem_d   [3];
    logic [WAIT_W-1:0] wait_q [3];
    logic [WAIT_W-1:0] wait_d [3];
    logic [CNT_W-1:0] jobs_q  [3];
    logic [CNT_W-1:0] jobs_d  [3];
    logic [CNT_W-1:0] pre_q   [3];
    logic [CNT_W-1:0] pre_d   [3];
    logic [2:0]       starved_q;
    logic [2:0]       starved_d;
    logic [2:0]       grant;
    logic [2:0]       fin;

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            grant[i] = (bus.accmodule == 2'(i + 1));
        end
    end

    always_comb begin
        starved_d = starved_q;
        fin       = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
            wait_d[i]  = wait_q[i];
            jobs_d[i]  = jobs_q[i];
            pre_d[i]   = pre_q[i];
            case (state_q[i])
                S_IDLE: begin
                    wait_d[i] = '0;
                    if (bus.job_valid[i]) begin
                        state_d[i] = S_REQ;
                        // A zero-length job still needs one granted cycle.
                        rem_d[i] = (bus.job_len[i*LEN_W +: LEN_W] == '0) ?
                                   LEN_W'(1) : bus.job_len[i*LEN_W +: LEN_W];
                    end
                end
                S_REQ, S_ACTIVE: begin
                    if (grant[i]) begin
                        wait_d[i] = '0;
                        if (rem_q[i] == LEN_W'(1)) begin
                            fin[i]     = 1'b1;
                            jobs_d[i]  = jobs_q[i] + CNT_W'(1);
                            state_d[i] = S_IDLE;
                        end else begin
                            rem_d[i]   = rem_q[i] - LEN_W'(1);
                            state_d[i] = S_ACTIVE;
                        end
                    end else if (state_q[i] == S_ACTIVE) begin
                        state_d[i] = S_REQ;
                        wait_d[i]  = '0;
                        if (pre_q[i] != '1) begin
                            pre_d[i] = pre_q[i] + CNT_W'(1);
                        end
                    end else begin
                        if (wait_q[i] != WAIT_W'(STARVE_LIMIT)) begin
                            wait_d[i] = wait_q[i] + WAIT_W'(1);
                        end
                        if (wait_d[i] == WAIT_W'(STARVE_LIMIT)) begin
                            starved_d[i] = 1'b1;
                        end
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // Handshake outputs are forced to their idle values while reset is held.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            bus.done[i]      = fin[i] & ~reset;
            bus.req[i]       = (state_q[i] != S_IDLE) & ~fin[i] & ~reset;
            bus.job_ready[i] = (state_q[i] == S_IDLE) | reset;
            jobs_done[i*CNT_W +: CNT_W]   = jobs_q[i];
            preempt_cnt[i*CNT_W +: CNT_W] = pre_q[i];
        end
        starved = starved_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= S_IDLE;
                rem_q[i]   <= '0;
                wait_q[i]  <= '0;
                jobs_q[i]  <= '0;
                pre_q[i]   <= '0;
            end
            starved_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
                wait_q[i]  <= wait_d[i];
                jobs_q[i]  <= jobs_d[i];
                pre_q[i]   <= pre_d[i];
            end
            starved_q <= starved_d;
        end
    end
endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter LEN_W, default 4, width of job length fields.
REQ-002 Parameter CNT_W, default 8, width of per-master statistics counters.
REQ-003 Parameter STARVE_LIMIT, default 64, consecutive ungranted request cycles before a starvation flag sets.
REQ-004 Port clk  input  1  clock, all logic on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port job_valid  input  3  per-master job offered; bit0=M1, bit1=M2, bit2=M3.
REQ-007 Port job_len  input  3*LEN_W  per-master job length in granted cycles; M1 at [LEN_W-1:0].
REQ-008 Port job_ready  output  3  per-master ready to accept a job.
REQ-009 Port accmodule  input  2  arbiter grant code: 00 none, 01 M1, 10 M2, 11 M3.
REQ-010 Port req  output  3  memory request to arbiter, per master.
REQ-011 Port done  output  3  per-master end-of-access to arbiter.
REQ-012 Port jobs_done  output  3*CNT_W  per-master completed-job count.
REQ-013 Port preempt_cnt  output  3*CNT_W  per-master count of grants lost before completion.
REQ-014 Port starved  output  3  per-master sticky starvation flag.

Function
REQ-015 Each master i SHALL have an independent FSM with states IDLE, REQ, ACTIVE and a remaining-cycles register rem_i (LEN_W bits).
REQ-016 job_ready[i] SHALL be 1 exactly when master i is in IDLE.
REQ-017 In IDLE with job_valid[i]=1, next state SHALL be REQ and rem_i SHALL load job_len_i; job_len_i=0 SHALL load 1.
REQ-018 Master i is granted in a cycle when accmodule equals its code (01, 10, 11 for M1, M2, M3).
REQ-019 In REQ, if granted, the FSM SHALL treat the cycle as an active cycle (decrement/finish exactly as in ACTIVE) and move to ACTIVE unless finished.
REQ-020 In ACTIVE or REQ while granted: if rem_i=1, done[i] SHALL be 1 that cycle (combinational on accmodule), jobs_done[i] SHALL increment (wrap at 2^CNT_W), next state IDLE; else rem_i SHALL decrement.
REQ-021 In ACTIVE while not granted (grant moved away), next state SHALL be REQ, rem_i retained, preempt_cnt[i] SHALL increment, saturating at all-ones.
REQ-022 req[i] SHALL be 1 in REQ and ACTIVE except in the cycle done[i]=1, where req[i] SHALL be 0 so the arbiter does not re-grant.
REQ-023 done[i] SHALL be 0 in every cycle not covered by REQ-020; done never asserts without grant.
REQ-024 A new job SHALL be accepted no earlier than the cycle after done[i]; IDLE entered by completion SHALL then accept on the following cycle per REQ-017.
REQ-025 A per-master wait counter SHALL count consecutive REQ cycles without grant, clear on grant or IDLE, saturate at STARVE_LIMIT, and set starved[i] when it reaches STARVE_LIMIT; starved[i] SHALL clear only on reset.
REQ-026 Masters SHALL be independent: simultaneous requests, completions and counter updates on different masters in the same cycle SHALL all take effect.
REQ-027 accmodule changes between active cycles SHALL only affect the masters whose grant status changed.

Reset
REQ-028 While reset=1 at a clock edge, all FSMs SHALL go to IDLE; rem, wait counters, jobs_done, preempt_cnt, starved SHALL clear to 0.
REQ-029 During and after reset, req=000, done=000, job_ready=111 until a job is accepted.
REQ-030 Reset mid-job SHALL abandon the job with no done pulse and no counter update.

Verification
REQ-031 M1 job_len=3, accmodule=01 from the cycle after req[0] rises -> done[0] on 3rd granted cycle, req[0]=0 that cycle, jobs_done[M1]=1.
REQ-032 M2 job_len=4, grant 10 for 2 cycles, then 01 for 3 cycles, then 10 -> preempt_cnt[M2]=1, req[1] high throughout loss, done[1] on 2nd regrant cycle.
REQ-033 All three job_valid=1 len=1 same cycle, accmodule 01,10,11 on successive cycles -> done 001,010,100 on those cycles, jobs_done each 1.
REQ-034 M3 job pending, accmodule held 00 for 64 cycles -> starved[2]=1 from cycle 64, remains 1 after later grant and completion.
REQ-035 Reset asserted while M1 ACTIVE rem=5 -> next cycle req=000, done=000, all counters 0, job_ready=111.
REQ-036 job_len=0 for M2 with immediate grant 10 -> single-cycle done[1], jobs_done[M2]=1.
